// File: rtl/axi_ads868x_pkg.sv
// Shared types, command constants and the mux-step search for the ADS868x sequencer.
package axi_ads868x_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [15:0] CMD_MAN_CH = 16'hC000;
  localparam logic [15:0] CMD_NOOP   = 16'h0000;
  localparam int          FRAME_BITS = 32;
  localparam int          DATA_BITS  = 16;

  typedef struct packed {
    logic [1:0] mux;
    logic [2:0] ch;
  } sample_user_t;

  // First enabled position after cur (cur itself is tried last); 0 when none is enabled.
  function automatic logic [1:0] next_mux(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] pos;
    logic [1:0] res;
    logic       found;
    res   = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      pos = cur + 2'(k);
      if (!found && en[pos]) begin
        res   = pos;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_ads868x_spi_frame.sv
// One 32-bit SPI frame: CS setup, 32 SCLK periods (MOSI on falling, MISO on rising edges),
// then CS release with a done pulse and the last 16 captured bits.
module axi_ads868x_spi_frame
  import axi_ads868x_pkg::*;
#(
  parameter int C_CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_cmd,
  input  logic                  i_miso,
  output logic                  o_cs_n,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_sclk_start,
  output logic                  o_done,
  output logic [DATA_BITS-1:0]  o_rdata
);

  localparam logic [7:0] DIV_LAST = 8'(C_CLK_DIV - 1);

  state_t                r_phase;
  logic [7:0]            r_div;
  logic [5:0]            r_half;
  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0]  r_rdata;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_done;
  logic                  w_div_end;

  assign w_div_end    = (r_div == DIV_LAST);
  assign o_sclk_start = (r_phase == SETUP) && w_div_end;
  assign o_cs_n       = r_cs_n;
  assign o_sclk       = r_sclk;
  assign o_mosi       = r_mosi;
  assign o_done       = r_done;
  assign o_rdata      = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= IDLE;
      r_div   <= 8'd0;
      r_half  <= 6'd0;
      r_tx    <= '0;
      r_rdata <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_phase)
        IDLE: if (i_start) begin
          r_phase <= SETUP;
          r_cs_n  <= 1'b0;
          r_div   <= 8'd0;
          r_tx    <= i_cmd;
          r_mosi  <= i_cmd[FRAME_BITS-1];
        end
        SETUP: if (w_div_end) begin
          r_div   <= 8'd0;
          r_half  <= 6'd0;
          r_sclk  <= 1'b1;
          r_phase <= SHIFT;
        end else begin
          r_div <= r_div + 8'd1;
        end
        SHIFT: if (w_div_end) begin
          r_div  <= 8'd0;
          r_half <= r_half + 6'd1;
          // Even halves are SCLK-high, odd halves SCLK-low; half 63 is the final low half.
          if (r_half == 6'd63) begin
            r_phase <= IDLE;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
          end else if (!r_half[0]) begin
            r_sclk <= 1'b0;
            r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
            r_mosi <= r_tx[FRAME_BITS-2];
          end else begin
            r_sclk <= 1'b1;
            if (r_half >= 6'd31) r_rdata <= {r_rdata[DATA_BITS-2:0], i_miso};
          end
        end else begin
          r_div <= r_div + 8'd1;
        end
        default: r_phase <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_ads868x_seq.sv
// ADS868x scan sequencer: C_NUM_CH+1 frames per trigger, mux stepping, single-slot AXIS output.
// Define ADS868X_TEST_PATTERN_EN to replace captured data with a per-sample counter.
module axi_ads868x_seq
  import axi_ads868x_pkg::*;
#(
  parameter int C_CLK_DIV = 2,
  parameter int C_NUM_CH  = 8,
  parameter int C_GAP     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_soft_reset,
  input  logic [3:0]  ctrl_ext_mux_en,
  input  logic        trig,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  ext_mux_sel,
  output logic [15:0] m_axis_tdata,
  output logic [4:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        stat_overflow,
  output logic        stat_trig_miss
);

  localparam logic [3:0]  NUM_CH_L = 4'(C_NUM_CH);
  localparam logic [15:0] GAP_LAST = 16'(C_GAP - 2);

  state_t                r_state, w_state_next;
  logic [3:0]            r_frame;
  logic [15:0]           r_gap;
  logic [1:0]            r_mux;
  logic                  r_tvalid;
  logic [15:0]           r_tdata;
  sample_user_t          r_tuser;
  logic                  r_overflow;
  logic                  r_trig_miss;
  logic                  w_rst;
  logic                  w_start;
  logic [3:0]            w_start_frame;
  logic [FRAME_BITS-1:0] w_cmd;
  logic                  w_gap_end;
  logic                  w_scan_end;
  logic                  w_sclk_start;
  logic                  w_done;
  logic                  w_load_req;
  logic [DATA_BITS-1:0]  w_rdata;

  assign w_rst          = rst | ctrl_soft_reset;
  assign w_gap_end      = (r_state == GAP) && (r_gap == GAP_LAST);
  assign w_scan_end     = w_gap_end && !(r_frame < NUM_CH_L);
  assign w_load_req     = w_done && (r_frame != 4'd0);
  assign busy           = (r_state != IDLE);
  assign ext_mux_sel    = r_mux;
  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tdata   = r_tdata;
  assign m_axis_tuser   = r_tuser;
  assign stat_overflow  = r_overflow;
  assign stat_trig_miss = r_trig_miss;

  axi_ads868x_spi_frame #(.C_CLK_DIV(C_CLK_DIV)) u_frame (
    .clk          (clk),
    .rst          (w_rst),
    .i_start      (w_start),
    .i_cmd        (w_cmd),
    .i_miso       (spi_miso),
    .o_cs_n       (spi_cs_n),
    .o_sclk       (spi_sclk),
    .o_mosi       (spi_mosi),
    .o_sclk_start (w_sclk_start),
    .o_done       (w_done),
    .o_rdata      (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_start_frame = r_frame;
    case (r_state)
      IDLE:  if (trig) begin
        w_state_next  = SETUP;
        w_start       = 1'b1;
        w_start_frame = 4'd0;
      end
      SETUP: if (w_sclk_start) w_state_next = SHIFT;
      SHIFT: if (w_done) w_state_next = GAP;
      GAP:   if (w_gap_end) begin
        if (r_frame < NUM_CH_L) begin
          w_state_next  = SETUP;
          w_start       = 1'b1;
          w_start_frame = r_frame + 4'd1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // Frame C_NUM_CH is the trailing NO_OP that flushes out the last channel's result.
    w_cmd = {CMD_NOOP, 16'h0000};
    if (w_start_frame < NUM_CH_L)
      w_cmd = {CMD_MAN_CH | {3'b000, w_start_frame[2:0], 10'b0}, 16'h0000};
  end

`ifdef ADS868X_TEST_PATTERN_EN
  logic [15:0] r_pattern;
`endif

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_frame     <= 4'd0;
      r_gap       <= 16'd0;
      r_mux       <= 2'd0;
      r_tvalid    <= 1'b0;
      r_tdata     <= 16'd0;
      r_tuser     <= '0;
      r_overflow  <= 1'b0;
      r_trig_miss <= 1'b0;
`ifdef ADS868X_TEST_PATTERN_EN
      r_pattern   <= 16'd0;
`endif
    end else begin
      if (w_start) r_frame <= w_start_frame;
      if (r_state == SHIFT && w_done) r_gap <= 16'd0;
      else if (r_state == GAP)        r_gap <= r_gap + 16'd1;
      if (w_scan_end) r_mux <= next_mux(r_mux, ctrl_ext_mux_en);
      if (trig && r_state != IDLE) r_trig_miss <= 1'b1;
      // A full slot that is not being drained drops the new sample; a draining slot reloads.
      if (w_load_req) begin
        if (r_tvalid && !m_axis_tready) begin
          r_overflow <= 1'b1;
        end else begin
          r_tvalid    <= 1'b1;
          r_tuser.mux <= r_mux;
          r_tuser.ch  <= r_frame[2:0] - 3'd1;
`ifdef ADS868X_TEST_PATTERN_EN
          r_tdata   <= r_pattern;
          r_pattern <= r_pattern + 16'd1;
`else
          r_tdata   <= w_rdata;
`endif
        end
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

endmodule
